// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: decodes load/store size, drives a single-outstanding
// request/ack bus with timeout, extracts load data and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] AluRes_i,
  input  logic [31:0] Op2_i,
  input  logic [31:0] PC_i,
  input  logic [31:0] Ins_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic        RegWr_i,
  input  logic [1:0]  MemtoReg_i,
  input  logic [4:0]  Rf_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] MemData_o,
  output logic [31:0] AluRes_o,
  output logic [31:0] PC_o,
  output logic [1:0]  MemtoReg_o,
  output logic        RegWr_o,
  output logic [4:0]  Rf_o,
  output logic        misalign_o,
  output logic        buserr_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_p1;
  size_t            size_p1;
  logic             uns_p1;
  logic             load_p1;
  logic [1:0]       lane_p1;

  size_t      size_p0;
  logic       uns_p0;
  logic       access_p0;
  logic       store_p0;
  logic       misalign_p0;
  logic       start_p0;
  logic       timeout_hit;
  logic       unused_ins;

  function automatic logic [3:0] byte_enable(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input size_t sz, input logic uns,
                                               input logic [1:0] a, input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Stage p0: decode the access presented by the EX/MEM register
  always_comb begin
    size_p0 = SZ_W;
    uns_p0  = 1'b0;
    case (Ins_i[31:26])
      6'h20: size_p0 = SZ_B;
      6'h24: begin size_p0 = SZ_B; uns_p0 = 1'b1; end
      6'h28: size_p0 = SZ_B;
      6'h21: size_p0 = SZ_H;
      6'h25: begin size_p0 = SZ_H; uns_p0 = 1'b1; end
      6'h29: size_p0 = SZ_H;
      default: size_p0 = SZ_W;
    endcase
  end

  assign unused_ins  = ^Ins_i[25:0];
  assign access_p0   = MemRd_i | MemWr_i;
  assign store_p0    = MemWr_i;
  assign misalign_p0 = access_p0 & (((size_p0 == SZ_W) & (AluRes_i[1:0] != 2'b00)) |
                                    ((size_p0 == SZ_H) & AluRes_i[0]));
  assign start_p0    = (state == IDLE) & access_p0 & ~misalign_p0;
  assign timeout_hit = (state == REQ) & ~bus_ack_i & (cnt_p1 == CNT_W'(TIMEOUT - 1));

  assign stall_o   = ~reset & (start_p0 | ((state == REQ) & ~bus_ack_i & ~timeout_hit));
  assign bus_req_o = ~reset & (state == REQ);

  // Stage p1: bus transaction and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt_p1      <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      MemData_o   <= '0;
      AluRes_o    <= '0;
      PC_o        <= '0;
      MemtoReg_o  <= '0;
      RegWr_o     <= 1'b0;
      Rf_o        <= '0;
      misalign_o  <= 1'b0;
      buserr_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      buserr_o   <= 1'b0;
      AluRes_o   <= AluRes_i;
      PC_o       <= PC_i;
      MemData_o  <= '0;
      case (state)
        IDLE: begin
          if (start_p0) begin
            state       <= REQ;
            cnt_p1      <= '0;
            bus_we_o    <= store_p0;
            bus_addr_o  <= {AluRes_i[31:2], 2'b00};
            bus_be_o    <= store_p0 ? byte_enable(size_p0, AluRes_i[1:0]) : 4'b1111;
            bus_wdata_o <= store_p0 ? store_data(size_p0, Op2_i) : '0;
            size_p1     <= size_p0;
            uns_p1      <= uns_p0;
            load_p1     <= ~store_p0;
            lane_p1     <= AluRes_i[1:0];
            RegWr_o     <= 1'b0;
            Rf_o        <= '0;
            MemtoReg_o  <= '0;
          end else begin
            misalign_o <= misalign_p0;
            RegWr_o    <= RegWr_i & ~misalign_p0;
            Rf_o       <= Rf_i;
            MemtoReg_o <= MemtoReg_i;
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            state      <= IDLE;
            MemData_o  <= load_p1 ? load_extract(size_p1, uns_p1, lane_p1, bus_rdata_i) : '0;
            RegWr_o    <= RegWr_i;
            Rf_o       <= Rf_i;
            MemtoReg_o <= MemtoReg_i;
          end else if (timeout_hit) begin
            state      <= IDLE;
            buserr_o   <= 1'b1;
            RegWr_o    <= 1'b0;
            Rf_o       <= Rf_i;
            MemtoReg_o <= MemtoReg_i;
          end else begin
            cnt_p1     <= cnt_p1 + 1'b1;
            RegWr_o    <= 1'b0;
            Rf_o       <= '0;
            MemtoReg_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads/stores of every size,
// misalignment, bus timeout, ack on the timeout cycle and reset during a request.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] AluRes_i, Op2_i, PC_i, Ins_i;
  logic        MemRd_i, MemWr_i, RegWr_i;
  logic [1:0]  MemtoReg_i;
  logic [4:0]  Rf_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic [31:0] MemData_o, AluRes_o, PC_o;
  logic [1:0]  MemtoReg_o;
  logic        RegWr_o;
  logic [4:0]  Rf_o;
  logic        misalign_o, buserr_o;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .AluRes_i(AluRes_i), .Op2_i(Op2_i), .PC_i(PC_i), .Ins_i(Ins_i),
    .MemRd_i(MemRd_i), .MemWr_i(MemWr_i), .RegWr_i(RegWr_i),
    .MemtoReg_i(MemtoReg_i), .Rf_i(Rf_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o),
    .MemData_o(MemData_o), .AluRes_o(AluRes_o), .PC_o(PC_o),
    .MemtoReg_o(MemtoReg_o), .RegWr_o(RegWr_o), .Rf_o(Rf_o),
    .misalign_o(misalign_o), .buserr_o(buserr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    Ins_i = '0; AluRes_i = '0; Op2_i = '0; PC_i = '0;
    MemRd_i = 0; MemWr_i = 0; RegWr_i = 0; MemtoReg_i = '0; Rf_i = '0;
  endtask

  // Present one access, hold it through the stall, ack after `waits` non-ack REQ cycles.
  task automatic do_access(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                           input logic [31:0] op2, input logic rd, input logic wr,
                           input logic [31:0] rdata, input int waits, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_mem);
    Ins_i = ins; AluRes_i = addr; Op2_i = op2; PC_i = 32'h0000_0400;
    MemRd_i = rd; MemWr_i = wr; RegWr_i = rd & ~wr;
    MemtoReg_i = rd ? 2'd1 : 2'd0; Rf_i = 5'd7; bus_ack_i = 0;
    #1;
    check({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    tick();
    check({tag, "_req"}, 32'(bus_req_o), 32'd1);
    check({tag, "_we"}, 32'(bus_we_o), 32'(wr));
    check({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
    check({tag, "_be"}, 32'(bus_be_o), 32'(exp_be));
    if (wr) check({tag, "_wdata"}, bus_wdata_o, exp_wdata);
    check({tag, "_bubble"}, 32'(RegWr_o), 32'd0);
    for (int i = 0; i < waits; i++) begin
      check({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
      tick();
    end
    bus_ack_i = 1; bus_rdata_i = rdata;
    #1;
    check({tag, "_ack_stall"}, 32'(stall_o), 32'd0);
    tick();
    bus_ack_i = 0;
    check({tag, "_memdata"}, MemData_o, exp_mem);
    check({tag, "_regwr"}, 32'(RegWr_o), 32'(rd & ~wr));
    check({tag, "_rf"}, 32'(Rf_o), 32'd7);
    check({tag, "_req_drop"}, 32'(bus_req_o), 32'd0);
    check({tag, "_buserr"}, 32'(buserr_o), 32'd0);
  endtask

  initial begin
    int k;
    set_nop();
    bus_ack_i = 0; bus_rdata_i = '0;
    reset = 1;
    tick(); tick();
    check("rst_memdata", MemData_o, 32'd0);
    check("rst_regwr", 32'(RegWr_o), 32'd0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    reset = 0;

    // ALU pass-through
    RegWr_i = 1; Rf_i = 5'd8; AluRes_i = 32'h0000_1234; PC_i = 32'h40; MemtoReg_i = 2'd0;
    #1;
    check("add_stall", 32'(stall_o), 32'd0);
    tick();
    check("add_alures", AluRes_o, 32'h0000_1234);
    check("add_regwr", 32'(RegWr_o), 32'd1);
    check("add_rf", 32'(Rf_o), 32'd8);
    check("add_pc", PC_o, 32'h40);
    check("add_memdata", MemData_o, 32'd0);

    // Loads and stores, back to back
    do_access("lb",   {6'h20, 26'h0}, 32'h103, 32'h0, 1, 0, 32'h80FF_FF00, 3, 4'b1111, 32'h0, 32'hFFFF_FF80);
    do_access("sh",   {6'h29, 26'h0}, 32'h102, 32'hABCD_1234, 0, 1, 32'h0, 0, 4'b1100, 32'h1234_1234, 32'h0);
    do_access("sb",   {6'h28, 26'h0}, 32'h101, 32'h5566_7788, 0, 1, 32'h0, 1, 4'b0010, 32'h8888_8888, 32'h0);
    do_access("sw",   {6'h2b, 26'h0}, 32'h200, 32'hDEAD_BEEF, 0, 1, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_access("lhu",  {6'h25, 26'h0}, 32'h102, 32'h0, 1, 0, 32'h8765_4321, 0, 4'b1111, 32'h0, 32'h0000_8765);
    do_access("lh",   {6'h21, 26'h0}, 32'h100, 32'h0, 1, 0, 32'h1234_8001, 2, 4'b1111, 32'h0, 32'hFFFF_8001);
    do_access("lbu",  {6'h24, 26'h0}, 32'h101, 32'h0, 1, 0, 32'h0000_AB00, 0, 4'b1111, 32'h0, 32'h0000_00AB);
    do_access("ldef", {6'h00, 26'h0}, 32'h104, 32'h0, 1, 0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);
    do_access("rdwr", {6'h2b, 26'h0}, 32'h010, 32'h0000_0055, 1, 1, 32'hFFFF_FFFF, 0, 4'b1111, 32'h0000_0055, 32'h0);
    do_access("to_ack", {6'h23, 26'h0}, 32'h020, 32'h0, 1, 0, 32'h1357_9BDF, 63, 4'b1111, 32'h0, 32'h1357_9BDF);

    // Misaligned word and half loads
    set_nop();
    Ins_i = {6'h23, 26'h0}; AluRes_i = 32'h101; MemRd_i = 1; RegWr_i = 1; Rf_i = 5'd3;
    #1;
    check("mis_w_stall", 32'(stall_o), 32'd0);
    check("mis_w_req", 32'(bus_req_o), 32'd0);
    tick();
    check("mis_w_pulse", 32'(misalign_o), 32'd1);
    check("mis_w_regwr", 32'(RegWr_o), 32'd0);
    check("mis_w_rf", 32'(Rf_o), 32'd3);
    check("mis_w_alures", AluRes_o, 32'h101);
    Ins_i = {6'h21, 26'h0};
    tick();
    check("mis_h_pulse", 32'(misalign_o), 32'd1);
    check("mis_h_req", 32'(bus_req_o), 32'd0);
    set_nop();
    tick();
    check("mis_drop", 32'(misalign_o), 32'd0);

    // Timeout with no ack
    Ins_i = {6'h23, 26'h0}; AluRes_i = 32'h40; MemRd_i = 1; RegWr_i = 1; Rf_i = 5'd9;
    tick();
    k = 1;
    while (k <= 200 && stall_o) begin
      tick();
      k++;
    end
    check("to_cycle", 32'(k), 32'd64);
    check("to_req_hold", 32'(bus_req_o), 32'd1);
    tick();
    set_nop();
    #1;
    check("to_buserr", 32'(buserr_o), 32'd1);
    check("to_regwr", 32'(RegWr_o), 32'd0);
    check("to_req_drop", 32'(bus_req_o), 32'd0);
    check("to_stall", 32'(stall_o), 32'd0);
    tick();
    check("to_buserr_drop", 32'(buserr_o), 32'd0);

    // Reset while a request is outstanding
    Ins_i = {6'h25, 26'h0}; AluRes_i = 32'h2; MemRd_i = 1; RegWr_i = 1; Rf_i = 5'd4;
    PC_i = 32'h88;
    tick();
    check("rr_req", 32'(bus_req_o), 32'd1);
    reset = 1;
    #1;
    check("rr_req_comb", 32'(bus_req_o), 32'd0);
    check("rr_stall_comb", 32'(stall_o), 32'd0);
    tick();
    check("rr_alures", AluRes_o, 32'd0);
    check("rr_pc", PC_o, 32'd0);
    check("rr_rf", 32'(Rf_o), 32'd0);
    check("rr_addr", bus_addr_o, 32'd0);
    set_nop();
    reset = 0;
    bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 0;
    check("rr_late_regwr", 32'(RegWr_o), 32'd0);
    check("rr_late_memdata", MemData_o, 32'd0);
    check("rr_late_req", 32'(bus_req_o), 32'd0);
    check("rr_late_buserr", 32'(buserr_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max REQ-state cycles without bus_ack_i before abort.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 AluRes_i  in  32  effective address / ALU result from EX/MEM register.
REQ-006 Op2_i  in  32  store data.
REQ-007 PC_i  in  32  instruction PC.
REQ-008 Ins_i  in  32  instruction; bits [31:26] select access size.
REQ-009 MemRd_i, MemWr_i, RegWr_i  in  1 each  control.
REQ-010 MemtoReg_i  in  2  writeback select; Rf_i  in  5  destination register.
REQ-011 bus_req_o, bus_we_o  out  1  bus request, write enable.
REQ-012 bus_addr_o  out  32  word address ({AluRes[31:2],2'b00}); bus_be_o  out  4  byte lanes; bus_wdata_o  out  32.
REQ-013 bus_ack_i  in  1  one-cycle completion; bus_rdata_i  in  32  read word, valid with ack.
REQ-014 stall_o  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 MemData_o, AluRes_o, PC_o  out  32; MemtoReg_o  out  2; RegWr_o  out  1; Rf_o  out  5: registered MEM/WB outputs.
REQ-016 misalign_o, buserr_o  out  1  registered one-cycle error pulses.

Function
REQ-017 Size decode: 0x23 lw, 0x21 lh, 0x25 lhu, 0x20 lb, 0x24 lbu, 0x2b sw, 0x29 sh, 0x28 sb; any other opcode with MemRd_i/MemWr_i SHALL be treated as word.
REQ-018 MemWr_i and MemRd_i both high SHALL be treated as a store.
REQ-019 Misaligned: word with addr[1:0]!=0, half with addr[0]!=0.
REQ-020 FSM states IDLE, REQ.
REQ-021 IDLE, no access: stall_o=0; next edge registers inputs into MEM/WB outputs (MemData_o<=0); 1-cycle latency.
REQ-022 IDLE, aligned access: stall_o=1; next edge -> REQ and latch addr/we/be/wdata/size; MEM/WB gets bubble (RegWr_o<=0, Rf_o<=0, MemtoReg_o<=0).
REQ-023 IDLE, misaligned access: no bus request, stall_o=0; next edge misalign_o<=1, RegWr_o<=0, MemData_o<=0, other outputs pass through.
REQ-024 REQ: bus_req_o=1 with all bus outputs stable until ack; stall_o = ~bus_ack_i.
REQ-025 REQ with bus_ack_i=1: next edge -> IDLE; MEM/WB outputs take instruction's values; MemData_o = extracted load data (0 for store).
REQ-026 Load extract (little-endian, lane n = bits [8n+7:8n] at addr[1:0]=n): lb/lh sign-extend, lbu/lhu zero-extend, lh/lhu lane pair selected by addr[1].
REQ-027 Store: sb replicates Op2[7:0] to 4 lanes, be=4'b0001<<addr[1:0]; sh replicates Op2[15:0], be=addr[1]?4'b1100:4'b0011; sw be=4'b1111.
REQ-028 Cycle counter SHALL count REQ cycles; when count reaches TIMEOUT with no ack: stall_o=0 that cycle, next edge -> IDLE, bus_req_o drops, buserr_o<=1, RegWr_o<=0.
REQ-029 Ack coincident with TIMEOUT cycle SHALL be treated as success.
REQ-030 bus_ack_i in IDLE SHALL be ignored.
REQ-031 Back-to-back accesses SHALL each take minimum 2 cycles (IDLE, REQ with ack).

Reset
REQ-032 reset high at an edge SHALL force IDLE, counter 0, all registered outputs 0; bus_req_o=0, stall_o=0 while reset high.
REQ-033 reset during REQ SHALL abort the transaction without error pulse; late ack ignored.

Verification
REQ-034 add (RegWr=1, Rf=8, AluRes=0x1234) -> no stall; next cycle AluRes_o=0x1234, RegWr_o=1, Rf_o=8.
REQ-035 lb at 0x103, ack after 3 REQ cycles, rdata=0x80FF_FF00 -> stall 4 cycles, be=4'b1111-ignored read, MemData_o=0xFFFF_FF80.
REQ-036 sh at 0x102, Op2=0xABCD_1234, ack in first REQ cycle -> bus_we=1, addr=0x100, be=4'b1100, wdata=0x1234_1234; RegWr_o=0.
REQ-037 lw at 0x101 -> no bus_req, no stall; misalign_o pulses 1 cycle, RegWr_o=0.
REQ-038 lw, ack never -> after TIMEOUT=64 REQ cycles buserr_o pulses, stall_o released, state IDLE.
REQ-039 lhu at 0x2 in REQ, reset asserted -> next cycle bus_req_o=0, all outputs 0; subsequent ack produces no writeback.
